// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared defaults and helpers for the 2-read / 1-write
//               register file and its busy scoreboard.
//               Contents:
//                 DWIDTH_DEF - default register/port data width
//                 NREGS_DEF  - default register count (power of two)
//                 clog2()    - ceiling log2, used to derive address widths
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int DWIDTH_DEF = 16;
  localparam int NREGS_DEF  = 8;

  // Ceiling log2; evaluated at elaboration time to size address buses.
  function automatic int clog2(input int value);
    int r_bits;
    int w_val;
    r_bits = 0;
    w_val  = value - 1;
    while (w_val > 0) begin
      r_bits = r_bits + 1;
      w_val  = w_val >> 1;
    end
    return r_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : One busy bit per register. A lock marks a register as having
//               a result in flight; a write retires it. When lock and write
//               hit the same register in the same cycle the lock wins, since
//               that means a newer result is now pending.
// Ports       :
//   clk          in   system clock
//   rst          in   synchronous active-high reset, clears all busy bits
//   i_lock_en    in   mark register i_lock_addr busy
//   i_lock_addr  in   register to mark
//   i_wr_en      in   write in progress, clears busy on i_wr_addr
//   i_wr_addr    in   register being written
//   o_busy_next  out  busy vector as it will be after this edge (comb)
//   o_any_busy   out  registered OR of the post-edge busy vector
// Config      : REG_FILE_ZERO_REG_EN - when defined, locks of register 0
//               are ignored so it can never report busy.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS  = NREGS_DEF,
  localparam int AWIDTH = clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_lock_en,
  input  logic [AWIDTH-1:0] i_lock_addr,
  input  logic              i_wr_en,
  input  logic [AWIDTH-1:0] i_wr_addr,
  output logic [NREGS-1:0]  o_busy_next,
  output logic              o_any_busy
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;
  logic             w_lock_ok;

`ifdef REG_FILE_ZERO_REG_EN
  assign w_lock_ok = i_lock_en && (i_lock_addr != '0);
`else
  assign w_lock_ok = i_lock_en;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi = gi + 1) begin : g_bit
      assign w_set[gi]       = w_lock_ok && (i_lock_addr == AWIDTH'(gi));
      assign w_clr[gi]       = i_wr_en   && (i_wr_addr   == AWIDTH'(gi));
      // Set has priority over clear.
      assign o_busy_next[gi] = w_set[gi] | (r_busy[gi] & ~w_clr[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= '0;
      o_any_busy <= 1'b0;
    end else begin
      r_busy     <= o_busy_next;
      o_any_busy <= |o_busy_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_file_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_2r1w
// Description : Parametrised register file with two registered read ports,
//               one write port, same-cycle write-to-read forwarding and a
//               per-register busy scoreboard for stalling on pending results.
// Ports       :
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   ra_en      in   port A read request
//   ra_addr    in   port A register index
//   ra_data    out  port A registered read data (valid cycle after ra_en)
//   ra_busy    out  port A registered busy flag of the register read
//   rb_en      in   port B read request
//   rb_addr    in   port B register index
//   rb_data    out  port B registered read data
//   rb_busy    out  port B registered busy flag
//   wr_en      in   write request
//   wr_addr    in   write index
//   wr_data    in   write data
//   lock_en    in   mark register pending
//   lock_addr  in   register to mark
//   any_busy   out  registered OR of all busy bits
// Config      : REG_FILE_ZERO_REG_EN - when defined, register 0 is hardwired
//               to zero: writes/locks to it are ignored, reads return 0 with
//               busy 0 and forwarding never applies to it.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_2r1w
  import regfile_pkg::*;
#(
  parameter  int DWIDTH = DWIDTH_DEF,
  parameter  int NREGS  = NREGS_DEF,
  localparam int AWIDTH = clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ra_en,
  input  logic [AWIDTH-1:0] ra_addr,
  output logic [DWIDTH-1:0] ra_data,
  output logic              ra_busy,
  input  logic              rb_en,
  input  logic [AWIDTH-1:0] rb_addr,
  output logic [DWIDTH-1:0] rb_data,
  output logic              rb_busy,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              lock_en,
  input  logic [AWIDTH-1:0] lock_addr,
  output logic              any_busy
);

  logic [DWIDTH-1:0] r_mem [NREGS];
  logic [NREGS-1:0]  w_busy_next;
  logic              w_wr_ok;
  logic              w_ra_fwd;
  logic              w_rb_fwd;
  logic [DWIDTH-1:0] w_ra_rdata;
  logic [DWIDTH-1:0] w_rb_rdata;

  reg_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .i_lock_en   (lock_en),
    .i_lock_addr (lock_addr),
    .i_wr_en     (wr_en),
    .i_wr_addr   (wr_addr),
    .o_busy_next (w_busy_next),
    .o_any_busy  (any_busy)
  );

`ifdef REG_FILE_ZERO_REG_EN
  assign w_wr_ok = wr_en && (wr_addr != '0);
`else
  assign w_wr_ok = wr_en;
`endif

  // Write qualification already excludes register 0 in zero-reg builds,
  // so forwarding can never target it.
  assign w_ra_fwd = w_wr_ok && (wr_addr == ra_addr);
  assign w_rb_fwd = w_wr_ok && (wr_addr == rb_addr);

`ifdef REG_FILE_ZERO_REG_EN
  assign w_ra_rdata = (ra_addr == '0) ? '0 : (w_ra_fwd ? wr_data : r_mem[ra_addr]);
  assign w_rb_rdata = (rb_addr == '0) ? '0 : (w_rb_fwd ? wr_data : r_mem[rb_addr]);
`else
  assign w_ra_rdata = w_ra_fwd ? wr_data : r_mem[ra_addr];
  assign w_rb_rdata = w_rb_fwd ? wr_data : r_mem[rb_addr];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Busy flags follow the post-edge scoreboard value so a same-cycle write
  // shows as cleared and a same-cycle lock shows as set.
  always_ff @(posedge clk) begin
    if (rst) begin
      ra_data <= '0;
      ra_busy <= 1'b0;
      rb_data <= '0;
      rb_busy <= 1'b0;
    end else begin
      if (ra_en) begin
        ra_data <= w_ra_rdata;
        ra_busy <= w_busy_next[ra_addr];
      end
      if (rb_en) begin
        rb_data <= w_rb_rdata;
        rb_busy <= w_busy_next[rb_addr];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_2r1w
// Description : Self-checking bench for reg_file_2r1w. Each table row is one
//               clock cycle of inputs plus the outputs expected after that
//               edge. Honours REG_FILE_ZERO_REG_EN for the register-0 rows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_2r1w;

  localparam int DW = 16;
  localparam int NR = 8;
  localparam int AW = 3;

`ifdef REG_FILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ra_en, rb_en, wr_en, lock_en;
  logic [AW-1:0] ra_addr, rb_addr, wr_addr, lock_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] ra_data, rb_data;
  logic          ra_busy, rb_busy, any_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_file_2r1w #(
    .DWIDTH (DW),
    .NREGS  (NR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ra_en     (ra_en),
    .ra_addr   (ra_addr),
    .ra_data   (ra_data),
    .ra_busy   (ra_busy),
    .rb_en     (rb_en),
    .rb_addr   (rb_addr),
    .rb_data   (rb_data),
    .rb_busy   (rb_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .lock_en   (lock_en),
    .lock_addr (lock_addr),
    .any_busy  (any_busy)
  );

  typedef struct {
    logic          rst;
    logic          ae;
    logic [AW-1:0] aa;
    logic          be;
    logic [AW-1:0] ba;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          le;
    logic [AW-1:0] la;
    logic [DW-1:0] e_ra;
    logic [DW-1:0] e_rb;
    logic          e_rab;
    logic          e_rbb;
    logic          e_any;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit ae, int aa, bit be, int ba,
                              bit we, int wa, int wd, bit le, int la,
                              int era, int erb, bit erab, bit erbb, bit eany);
    vec_t v;
    v.rst = r;  v.ae = ae; v.aa = AW'(aa); v.be = be; v.ba = AW'(ba);
    v.we  = we; v.wa = AW'(wa); v.wd = DW'(wd); v.le = le; v.la = AW'(la);
    v.e_ra = DW'(era); v.e_rb = DW'(erb);
    v.e_rab = erab; v.e_rbb = erbb; v.e_any = eany;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    rst = v.rst; ra_en = v.ae; ra_addr = v.aa; rb_en = v.be; rb_addr = v.ba;
    wr_en = v.we; wr_addr = v.wa; wr_data = v.wd; lock_en = v.le; lock_addr = v.la;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input vec_t v, input int idx);
    chk("ra_data",  idx, 32'(ra_data),  32'(v.e_ra));
    chk("rb_data",  idx, 32'(rb_data),  32'(v.e_rb));
    chk("ra_busy",  idx, 32'(ra_busy),  32'(v.e_rab));
    chk("rb_busy",  idx, 32'(rb_busy),  32'(v.e_rbb));
    chk("any_busy", idx, 32'(any_busy), 32'(v.e_any));
  endtask

  initial begin
    vec_t h;
    rst = 1'b1; ra_en = 0; rb_en = 0; wr_en = 0; lock_en = 0;
    ra_addr = '0; rb_addr = '0; wr_addr = '0; lock_addr = '0; wr_data = '0;

    //             rst ae aa be ba we wa wd       le la  ra       rb       rab rbb any
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0,       0, 0, 0)); // 0 reset
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0,       0, 0, 0)); // 1 reset
    vecs.push_back(mk(0, 1, 3, 1, 5, 0, 0, 0,       0, 0, 0,       0,       0, 0, 0)); // 2 read r3/r5
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2, 'h1234,  0, 0, 0,       0,       0, 0, 0)); // 3 write r2
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0,       0, 0, 'h1234,  0,       0, 0, 0)); // 4 read r2
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 4, 'h1111,  0, 0, 'h1234,  0,       0, 0, 0)); // 5 old r4
    vecs.push_back(mk(0, 1, 4, 1, 4, 1, 4, 'hBEEF,  0, 0, 'hBEEF,  'hBEEF,  0, 0, 0)); // 6 forward both
    vecs.push_back(mk(0, 1, 4, 0, 0, 0, 0, 0,       0, 0, 'hBEEF,  'hBEEF,  0, 0, 0)); // 7 array r4
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,       1, 6, 'hBEEF,  'hBEEF,  0, 0, 1)); // 8 lock r6
    vecs.push_back(mk(0, 1, 6, 0, 0, 0, 0, 0,       0, 0, 0,       'hBEEF,  1, 0, 1)); // 9 read busy r6
    vecs.push_back(mk(0, 1, 6, 1, 6, 1, 6, 'h0055,  1, 6, 'h0055,  'h0055,  1, 1, 1)); // 10 lock+write r6
    vecs.push_back(mk(0, 1, 6, 0, 0, 1, 6, 'h0077,  0, 0, 'h0077,  'h0055,  0, 1, 0)); // 11 retire r6
    vecs.push_back(mk(0, 0, 0, 1, 5, 1, 5, 'h5555,  1, 3, 'h0077,  'h5555,  0, 0, 1)); // 12 lock r3, wr r5
    vecs.push_back(mk(0, 1, 3, 1, 5, 0, 0, 0,       0, 0, 0,       'h5555,  1, 0, 1)); // 13
    vecs.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0,       1, 3, 0,       'h5555,  1, 0, 1)); // 14 relock r3
    vecs.push_back(mk(0, 1, 3, 0, 0, 1, 3, 'h3333,  0, 0, 'h3333,  'h5555,  0, 0, 0)); // 15 retire r3
    vecs.push_back(mk(0, 0, 0, 1, 7, 1, 7, 'h7777,  0, 0, 'h3333,  'h7777,  0, 0, 0)); // 16 write idle r7
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 'hAAAA,  1, 1, 'h3333,  'h7777,  0, 0, 1)); // 17 lock+write r1
    vecs.push_back(mk(1, 1, 1, 1, 2, 1, 2, 'h9999,  1, 2, 0,       0,       0, 0, 0)); // 18 reset wins
    vecs.push_back(mk(0, 1, 1, 1, 2, 0, 0, 0,       0, 0, 0,       0,       0, 0, 0)); // 19 r1/r2 cleared
    // Register 0 rows: expectations depend on the hardwired-zero option.
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 'hFFFF,  1, 0, 0,       0,       0, 0, !ZR));      // 20
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0,       0, 0, ZR ? 0 : 'hFFFF, ZR ? 0 : 'hFFFF,
                      !ZR, !ZR, !ZR));                                                      // 21
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 'h1234,  0, 0, ZR ? 0 : 'h1234, ZR ? 0 : 'hFFFF,
                      0, !ZR, 0));                                                          // 22

    foreach (vecs[i]) begin
      drive(vecs[i]);
      check_outs(vecs[i], i);
    end

    // Hand sequence: write lands in the array, read data holds while ra_en=0,
    // then appears one cycle after the read request.
    h = mk(0, 0, 0, 0, 0, 1, 5, 'hCAFE, 0, 0, 0, 0, 0, 0, 0);
    drive(h);
    chk("hold_ra_data", 100, 32'(ra_data), ZR ? 32'h0 : 32'h1234);
    h = mk(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(h);
    chk("latency_ra_data", 101, 32'(ra_data), 32'hCAFE);
    chk("latency_ra_busy", 101, 32'(ra_busy), 32'h0);

    // Hand sequence: lock on one register and write on another both apply.
    h = mk(0, 1, 5, 1, 7, 1, 7, 'h0707, 1, 5, 0, 0, 0, 0, 0);
    drive(h);
    chk("split_ra_busy", 102, 32'(ra_busy), 32'h1);
    chk("split_rb_data", 102, 32'(rb_data), 32'h0707);
    chk("split_rb_busy", 102, 32'(rb_busy), 32'h0);
    chk("split_any",     102, 32'(any_busy), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Parametrised successor to the 8x16 single-port register bank.
- Two independent read ports and one write port, all synchronous; read data is registered.
- Same-cycle write-to-read forwarding.
- Per-register busy scoreboard so the control unit can stall on pending results.
- Sits between the bus/ALU datapath and the microsequencer; feeds the ALU X/Y operand registers directly.

Parameters:
- DWIDTH, 16, data width of every register and port
- NREGS, 8, number of registers; power of two, 2..64
- AWIDTH, $clog2(NREGS), address width; derived, not overridden

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- ra_en  in  1  port A read request
- ra_addr  in  AWIDTH  port A register index
- ra_data  out  DWIDTH  port A registered read data
- ra_busy  out  1  port A registered busy flag for the register read
- rb_en  in  1  port B read request
- rb_addr  in  AWIDTH  port B register index
- rb_data  out  DWIDTH  port B registered read data
- rb_busy  out  1  port B registered busy flag
- wr_en  in  1  write request
- wr_addr  in  AWIDTH  write index
- wr_data  in  DWIDTH  write data
- lock_en  in  1  mark register pending (result in flight)
- lock_addr  in  AWIDTH  register to mark
- any_busy  out  1  OR of all busy bits, registered

Behaviour:
- Reset:
  - rst=1 at a rising edge clears all registers, all busy bits, ra_data, rb_data, ra_busy, rb_busy and any_busy to 0.
  - rst overrides every request in the same cycle, including one mid-lock or mid-write.
- Write:
  - wr_en=1 stores wr_data into reg[wr_addr] at the edge.
  - Visible through the array on the next cycle's read.
- Read latency:
  - ra_en=1 in cycle N gives ra_data valid in cycle N+1.
  - ra_en=0: ra_data and ra_busy hold their previous values.
  - Port B behaves identically and independently.
- Forwarding:
  - If wr_en=1 and wr_addr==ra_addr while ra_en=1 in the same cycle, ra_data takes wr_data, not the old array value.
  - Port B likewise.
  - Both ports may read the same address; both get identical data.
- Busy scoreboard, one bit per register:
  - lock_en sets busy[lock_addr].
  - wr_en clears busy[wr_addr].
  - Simultaneous lock and write to the same address: set wins, i.e. a new result is pending.
  - Lock and write to different addresses: both apply.
  - Lock of an already-busy register: stays busy, no error.
  - Write to a non-busy register: legal, busy stays 0.
- Busy outputs:
  - ra_busy and rb_busy capture the post-edge busy value (busy_next) of the addressed register.
  - Therefore a same-cycle write clears it and a same-cycle lock sets it.
  - any_busy = OR of busy_next, updated every cycle regardless of the read enables.
- Array width: no width conversion; addresses are always in range because NREGS is a power of two.

Optional Feature:
- Macro: REG_FILE_ZERO_REG_EN
- Defined: register 0 is hardwired zero.
  - Writes and locks to index 0 are ignored.
  - Reads of index 0 return 0 and busy 0.
  - Forwarding never applies to index 0.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Package regfile_pkg:
  - DWIDTH default constant
  - NREGS default constant
  - clog2 helper
- Sub-module reg_scoreboard:
  - Contains the NREGS busy bits, set/clear priority logic, busy_next vector and any_busy.
  - Instantiated once.
- The data array and read/forward muxes stay in the top module.

Test Plan:
- Reset then read: rst=1 for 2 cycles; read A addr 3, B addr 5 -> ra_data=0, rb_data=0, ra_busy=0, any_busy=0.
- Write/read latency: write 0x1234 to r2 in cycle N; ra_en addr 2 in cycle N+1 -> ra_data=0x1234 in N+2.
- Forwarding: same cycle wr_en addr 4 data 0xBEEF and ra_en/rb_en addr 4 -> ra_data=rb_data=0xBEEF next cycle, not the old value.
- Scoreboard:
  - lock r6 -> any_busy=1, read r6 gives ra_busy=1.
  - Same-cycle lock r6 + write r6 0x0055 -> r6 stays busy, data 0x0055.
  - Later write r6 -> busy cleared, any_busy=0.
- Mid-operation reset: lock r1, write r1 0xAAAA, assert rst the cycle after -> r1=0, busy=0, outputs 0.
- REG_FILE_ZERO_REG_EN: write r0 0xFFFF, lock r0 -> read r0 gives 0, busy 0, any_busy=0; without the macro it reads 0xFFFF, busy 1.
